// File: rtl/hazard_stall_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit_pkg
// Shared constants and helpers for the ID-stage hazard/stall logic.
//   REG_ZERO        : architectural zero register address (never a real producer)
//   DEF_REG_AW      : default register address width
//   DEF_SAD_LAT     : default SAD-unit busy window after a readSAD issues
//   DEF_STAT_W      : default width of the stall-cycle statistics counter
//   cntWidth(lat)   : bits needed to hold the values 0..lat
// ---------------------------------------------------------------------------
package hazard_stall_unit_pkg;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         DEF_REG_AW  = 5;
    localparam int         DEF_SAD_LAT = 4;
    localparam int         DEF_STAT_W  = 16;

    // Width of a down-counter that must represent 0..lat inclusive.
    function automatic int cntWidth(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that increments once per enabled clock and sticks at all-ones.
//   Clk    : clock
//   Rst_n  : asynchronous active-low reset, clears count
//   enable : count this cycle
//   count  : current count, saturating at 2**W-1
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
// ID-stage hazard detector. Requests a bubble into ID/EX (and freezes PC and
// IF/ID) on a load-use hazard or while the SAD unit is still busy with an
// earlier readSAD and the ID instruction needs it.
//   Clk, Rst_n      : clock, asynchronous active-low reset
//   id_rs, id_rt    : source register fields of the IF/ID instruction
//   id_use_rs/rt    : the IF/ID instruction actually reads rs / rt
//   id_read_sad     : IF/ID instruction starts the SAD unit
//   id_sad_use      : IF/ID instruction consumes SAD results
//   id_flush        : IF/ID instruction is being squashed this cycle
//   ex_mem_read     : ID/EX instruction is a load
//   ex_dst          : ID/EX destination register (after RegDst mux)
//   stall           : 1 = inject bubble into ID/EX
//   pc_write        : PC write enable (low while stalled)
//   ifid_write      : IF/ID write enable (low while stalled)
//   sad_busy        : SAD busy window active
//   stall_cycles    : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_AW  = DEF_REG_AW,
    parameter int SAD_LAT = DEF_SAD_LAT,
    parameter int STAT_W  = DEF_STAT_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_read_sad,
    input  logic              id_sad_use,
    input  logic              id_flush,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dst,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              sad_busy,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam int               CNT_W    = cntWidth(SAD_LAT);
    localparam logic [CNT_W-1:0] SAD_LOAD = CNT_W'(SAD_LAT);

    logic [CNT_W-1:0] sadCnt;
    logic             dstNonZero;
    logic             rsMatch;
    logic             rtMatch;
    logic             loadUse;
    logic             sadHz;
    logic             issue;

    // Load-use: the load in EX writes a register the ID instruction reads.
    // r0 is hardwired, so a load "into" r0 never produces a hazard.
    assign dstNonZero = (ex_dst != REG_AW'(REG_ZERO));
    assign rsMatch    = id_use_rs && (id_rs == ex_dst);
    assign rtMatch    = id_use_rt && (id_rt == ex_dst);
    assign loadUse    = ex_mem_read && dstNonZero && (rsMatch || rtMatch);

    // SAD structural/data hazard: results not ready, or unit still occupied
    // by the previous readSAD.
    assign sad_busy = (sadCnt != '0);
    assign sadHz    = sad_busy && (id_sad_use || id_read_sad);

    // A squashed instruction is discarded anyway, so it never waits.
    assign stall      = !id_flush && (loadUse || sadHz);
    assign pc_write   = !stall;
    assign ifid_write = !stall;

    // A readSAD only starts the unit when it actually leaves ID.
    assign issue = id_read_sad && !stall && !id_flush;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sadCnt <= '0;
        end else if (issue) begin
            sadCnt <= SAD_LOAD;
        end else if (sad_busy) begin
            sadCnt <= sadCnt - 1'b1;
        end else begin
            sadCnt <= '0;
        end
    end

    sat_counter #(
        .W(STAT_W)
    ) uStallStat (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .enable (stall),
        .count  (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int REG_AW  = 5;
  localparam int SAD_LAT = 4;
  localparam int STAT_W  = 16;
  localparam int SAT_W   = 3;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic [REG_AW-1:0] id_rs = '0;
  logic [REG_AW-1:0] id_rt = '0;
  logic id_use_rs = 1'b0;
  logic id_use_rt = 1'b0;
  logic id_read_sad = 1'b0;
  logic id_sad_use = 1'b0;
  logic id_flush = 1'b0;
  logic ex_mem_read = 1'b0;
  logic [REG_AW-1:0] ex_dst = '0;

  logic stall, pc_write, ifid_write, sad_busy;
  logic [STAT_W-1:0] stall_cycles;
  logic sat_stall, sat_pc_write, sat_ifid_write, sat_sad_busy;
  logic [SAT_W-1:0] sat_stall_cycles;

  hazard_stall_unit #(.REG_AW(REG_AW), .SAD_LAT(SAD_LAT), .STAT_W(STAT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_read_sad(id_read_sad),
    .id_sad_use(id_sad_use), .id_flush(id_flush), .ex_mem_read(ex_mem_read),
    .ex_dst(ex_dst), .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .sad_busy(sad_busy), .stall_cycles(stall_cycles)
  );

  // Narrow statistics counter instance for saturation checks.
  hazard_stall_unit #(.REG_AW(REG_AW), .SAD_LAT(SAD_LAT), .STAT_W(SAT_W)) dut_sat (
    .Clk(Clk), .Rst_n(Rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_read_sad(id_read_sad),
    .id_sad_use(id_sad_use), .id_flush(id_flush), .ex_mem_read(ex_mem_read),
    .ex_dst(ex_dst), .stall(sat_stall), .pc_write(sat_pc_write),
    .ifid_write(sat_ifid_write), .sad_busy(sat_sad_busy),
    .stall_cycles(sat_stall_cycles)
  );

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;  // expected stall_cycles of the wide instance

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_read_sad = 1'b0; id_sad_use = 1'b0; id_flush = 1'b0;
    ex_mem_read = 1'b0; ex_dst = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL reset_pc_write: got %0b want 1", pc_write); end
    total++; if (ifid_write !== 1'b1) begin bad++; $display("FAIL reset_ifid_write: got %0b want 1", ifid_write); end
    total++; if (sad_busy !== 1'b0) begin bad++; $display("FAIL reset_sad_busy: got %0b want 0", sad_busy); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge Clk);
    ex_mem_read = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_rs_stall: got %0b want 1", stall); end
    total++; if (pc_write !== 1'b0) begin bad++; $display("FAIL lu_rs_pc_write: got %0b want 0", pc_write); end
    total++; if (ifid_write !== 1'b0) begin bad++; $display("FAIL lu_rs_ifid_write: got %0b want 0", ifid_write); end
    @(negedge Clk);
    exp_cnt++;
    ex_mem_read = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_rs_release: got %0b want 0", stall); end
    total++; if (stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL lu_rs_count: got %0d want %0d", stall_cycles, exp_cnt); end
    // rt operand
    @(negedge Clk);
    id_use_rs = 1'b0; id_rs = 5'd3;
    ex_mem_read = 1'b1; ex_dst = 5'd12; id_rt = 5'd12; id_use_rt = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_rt_stall: got %0b want 1", stall); end
    @(negedge Clk);
    exp_cnt++;
    clear_inputs();
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_rt_release: got %0b want 0", stall); end
    total++; if (stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL lu_rt_count: got %0d want %0d", stall_cycles, exp_cnt); end
  endtask

  task automatic test_no_stall();
    @(negedge Clk);
    ex_mem_read = 1'b1; ex_dst = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_dst: got %0b want 0", stall); end
    id_use_rs = 1'b0; ex_dst = 5'd9; id_rt = 5'd9; id_use_rt = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rt_unused: got %0b want 0", stall); end
    id_use_rt = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rt_used: got %0b want 1", stall); end
    clear_inputs();
    @(negedge Clk);
    #1;
    total++; if (stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL no_stall_count: got %0d want %0d", stall_cycles, exp_cnt); end
  endtask

  task automatic test_sad_window();
    @(negedge Clk);
    id_read_sad = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL sad_issue_stall: got %0b want 0", stall); end
    @(negedge Clk);
    id_read_sad = 1'b0; id_sad_use = 1'b1;
    for (int i = 0; i < SAD_LAT; i++) begin
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL sad_wait_%0d: got %0b want 1", i, stall); end
      total++; if (sad_busy !== 1'b1) begin bad++; $display("FAIL sad_busy_%0d: got %0b want 1", i, sad_busy); end
      @(negedge Clk);
      exp_cnt++;
    end
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL sad_done_stall: got %0b want 0", stall); end
    total++; if (sad_busy !== 1'b0) begin bad++; $display("FAIL sad_done_busy: got %0b want 0", sad_busy); end
    total++; if (stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL sad_count: got %0d want %0d", stall_cycles, exp_cnt); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge Clk);
    id_read_sad = 1'b1;  // first readSAD issues this cycle
    @(negedge Clk);
    for (int i = 0; i < SAD_LAT; i++) begin
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_wait_%0d: got %0b want 1", i, stall); end
      @(negedge Clk);
      exp_cnt++;
    end
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_issue: got %0b want 0", stall); end
    @(negedge Clk);  // second readSAD issued on that edge, counter reloaded
    id_read_sad = 1'b0;
    #1;
    total++; if (sad_busy !== 1'b1) begin bad++; $display("FAIL b2b_reload: got %0b want 1", sad_busy); end
    for (int i = 0; i < SAD_LAT; i++) @(negedge Clk);
    #1;
    total++; if (sad_busy !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %0b want 0", sad_busy); end
    total++; if (stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL b2b_count: got %0d want %0d", stall_cycles, exp_cnt); end
  endtask

  task automatic test_flush_and_reset();
    // flushed readSAD must not start the unit
    @(negedge Clk);
    id_flush = 1'b1; id_read_sad = 1'b1;
    @(negedge Clk);
    clear_inputs();
    #1;
    total++; if (sad_busy !== 1'b0) begin bad++; $display("FAIL flush_no_load: got %0b want 0", sad_busy); end
    // real issue, then flush against both hazards
    @(negedge Clk);
    id_read_sad = 1'b1;
    @(negedge Clk);
    id_read_sad = 1'b0; id_flush = 1'b1; id_sad_use = 1'b1;
    ex_mem_read = 1'b1; ex_dst = 5'd7; id_rs = 5'd7; id_use_rs = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %0b want 0", stall); end
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL flush_pc_write: got %0b want 1", pc_write); end
    @(negedge Clk);  // counter 3
    id_flush = 1'b0; ex_mem_read = 1'b0; id_use_rs = 1'b0;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL unflush_stall: got %0b want 1", stall); end
    @(negedge Clk);  // counter 2, one stalled edge
    exp_cnt++;
    #1;
    total++; if (stall_cycles !== 16'(exp_cnt)) begin bad++; $display("FAIL flush_count: got %0d want %0d", stall_cycles, exp_cnt); end
    // asynchronous reset mid-countdown
    #1;
    Rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    total++; if (sad_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %0b want 0", sad_busy); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL rst_mid_count: got %0d want 0", stall_cycles); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall: got %0b want 0", stall); end
    clear_inputs();
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    @(negedge Clk);
    ex_mem_read = 1'b1; ex_dst = 5'd20; id_rt = 5'd20; id_use_rt = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      exp_cnt++;
    end
    #1;
    total++; if (sat_stall_cycles !== 3'd7) begin bad++; $display("FAIL sat_at_7: got %0d want 7", sat_stall_cycles); end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      exp_cnt++;
    end
    #1;
    total++; if (sat_stall_cycles !== 3'd7) begin bad++; $display("FAIL sat_hold: got %0d want 7", sat_stall_cycles); end
    total++; if (stall_cycles !== 16'd10) begin bad++; $display("FAIL wide_10: got %0d want 10", stall_cycles); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_sad_window();
    test_back_to_back();
    test_flush_and_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
